// File: rtl/cv32e40s_alert_esc_if.sv
// Alert/escalation bus between the alert sources, the escalation handler and
// cv32e40s_alert_esc. Signal names keep the DUT-side direction suffixes.
`timescale 1ns/1ps

interface cv32e40s_alert_esc_if #(
  parameter int unsigned CNT_W = 4
);
  logic             alert_minor_i;
  logic             alert_major_i;
  logic             esc_ack_i;
  logic             esc_req_o;
  logic [1:0]       esc_cause_o;
  logic [CNT_W-1:0] minor_cnt_o;
  logic [7:0]       esc_cnt_o;

  // Alert sources and escalation handler side.
  modport master (
    output alert_minor_i, alert_major_i, esc_ack_i,
    input  esc_req_o, esc_cause_o, minor_cnt_o, esc_cnt_o
  );

  // Escalation block side.
  modport slave (
    input  alert_minor_i, alert_major_i, esc_ack_i,
    output esc_req_o, esc_cause_o, minor_cnt_o, esc_cnt_o
  );
endinterface

// File: rtl/cv32e40s_alert_esc.sv
// Alert escalation: leaky minor-alert counter plus a four-phase escalation
// request FSM with sticky pending causes and a saturating escalation counter.
`timescale 1ns/1ps

module cv32e40s_alert_esc #(
  parameter int unsigned CNT_W           = 4,
  parameter int unsigned MINOR_THRESHOLD = 8,
  parameter int unsigned LEAK_PERIOD     = 1024
) (
  input logic                 clk,
  input logic                 rst,
  cv32e40s_alert_esc_if.slave bus
);

  localparam int unsigned       LEAK_W    = $clog2(LEAK_PERIOD);
  localparam logic [LEAK_W-1:0] LEAK_LAST = LEAK_W'(LEAK_PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  THRESHOLD = CNT_W'(MINOR_THRESHOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e            state_q;
  logic [LEAK_W-1:0] leak_q, leak_d;
  logic [CNT_W-1:0]  minor_q, minor_d;
  logic [CNT_W-1:0]  minor_inc;
  logic [1:0]        cause_q, pending_q;
  logic [1:0]        events;
  logic              esc_req_q;
  logic [7:0]        esc_cnt_q;
  logic              leak;
  logic              minor_esc;

  // NOTE: every signal gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    leak      = (leak_q == LEAK_LAST);
    leak_d    = leak ? '0 : leak_q + LEAK_W'(1);
    minor_inc = (minor_q == CNT_MAX) ? minor_q : minor_q + CNT_W'(1);
    minor_esc = 1'b0;
    minor_d   = minor_q;

    // A leak and an alert in the same cycle cancel out.
    if (bus.alert_minor_i && !leak) begin
      if (minor_inc >= THRESHOLD) begin
        minor_esc = 1'b1;
        minor_d   = '0;
      end else begin
        minor_d = minor_inc;
      end
    end else if (leak && !bus.alert_minor_i && (minor_q != '0)) begin
      minor_d = minor_q - CNT_W'(1);
    end

    events = {minor_esc, bus.alert_major_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      leak_q  <= '0;
      minor_q <= '0;
    end else begin
      leak_q  <= leak_d;
      minor_q <= minor_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cause_q   <= 2'b00;
      pending_q <= 2'b00;
      esc_req_q <= 1'b0;
      esc_cnt_q <= 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (events != 2'b00) begin
            state_q   <= REQ;
            cause_q   <= events;
            esc_req_q <= 1'b1;
          end
        end
        REQ: begin
          pending_q <= pending_q | events;
          if (bus.esc_ack_i) begin
            state_q   <= WAIT;
            esc_req_q <= 1'b0;
            if (esc_cnt_q != 8'hFF) esc_cnt_q <= esc_cnt_q + 8'd1;
          end
        end
        WAIT: begin
          if (bus.esc_ack_i) begin
            pending_q <= pending_q | events;
          end else if ((pending_q | events) != 2'b00) begin
            // Re-request immediately; this cycle's events fold into the cause.
            state_q   <= REQ;
            cause_q   <= pending_q | events;
            pending_q <= 2'b00;
            esc_req_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            cause_q <= 2'b00;
          end
        end
        default: begin
          state_q   <= IDLE;
          cause_q   <= 2'b00;
          pending_q <= 2'b00;
          esc_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.esc_req_o   = esc_req_q;
  assign bus.esc_cause_o = cause_q;
  assign bus.minor_cnt_o = minor_q;
  assign bus.esc_cnt_o   = esc_cnt_q;

endmodule

// File: tb/tb_cv32e40s_alert_esc.sv
// Self-checking bench for cv32e40s_alert_esc: per-scenario stimulus rows push
// their expected outputs to a scoreboard that is popped after each clock edge.
`timescale 1ns/1ps

module tb_cv32e40s_alert_esc;

  typedef struct packed {
    logic       req;
    logic [1:0] cause;
    logic [3:0] minor;
    logic [7:0] escc;
  } obs_t;

  typedef struct packed {
    logic rst;
    logic minor;
    logic major;
    logic ack;
    obs_t exp;
  } row_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  obs_t sb_q[$];

  cv32e40s_alert_esc_if #(.CNT_W(4)) bus ();

  cv32e40s_alert_esc #(
    .CNT_W(4),
    .MINOR_THRESHOLD(8),
    .LEAK_PERIOD(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(input logic rs, input logic mi, input logic ma,
                              input logic ak, input logic rq, input logic [1:0] c,
                              input logic [3:0] m, input logic [7:0] e);
    row_t r;
    r.rst = rs; r.minor = mi; r.major = ma; r.ack = ak;
    r.exp = '{req: rq, cause: c, minor: m, escc: e};
    return r;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("req=%b cause=%b minor=%0d esc_cnt=%0d", o.req, o.cause, o.minor, o.escc);
  endfunction

  function automatic obs_t sample();
    return '{req: bus.esc_req_o, cause: bus.esc_cause_o,
             minor: bus.minor_cnt_o, escc: bus.esc_cnt_o};
  endfunction

  // Apply one cycle of inputs, queue the outputs expected after the edge,
  // and advance to just past that edge.
  task automatic drive(input row_t r);
    rst               = r.rst;
    bus.alert_minor_i = r.minor;
    bus.alert_major_i = r.major;
    bus.esc_ack_i     = r.ack;
    sb_q.push_back(r.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    obs_t obs, exp;
    rows.push_back(mk(1, 1, 1, 1, 0, 2'b00, 0, 0));
    rows.push_back(mk(1, 1, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 2'b00, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      obs = sample();
      exp = sb_q.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reset[%0d] got %s expected %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_major();
    row_t rows[$];
    obs_t obs, exp;
    rows.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 1, 2'b01, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 1, 2'b01, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 1, 2'b01, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 1, 2'b01, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 2'b01, 0, 1));
    rows.push_back(mk(0, 0, 0, 1, 0, 2'b01, 0, 1));
    rows.push_back(mk(0, 0, 0, 1, 0, 2'b01, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1));
    rows.push_back(mk(0, 0, 0, 1, 0, 2'b00, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1));
    foreach (rows[i]) begin
      drive(rows[i]);
      obs = sample();
      exp = sb_q.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL major[%0d] got %s expected %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_threshold();
    row_t rows[$];
    obs_t obs, exp;
    rows.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0));
    for (int k = 1; k <= 7; k++) rows.push_back(mk(0, 1, 0, 0, 0, 2'b00, 4'(k), 0));
    rows.push_back(mk(0, 1, 0, 0, 1, 2'b10, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 2'b10, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1));
    foreach (rows[i]) begin
      drive(rows[i]);
      obs = sample();
      exp = sb_q.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL threshold[%0d] got %s expected %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_pending();
    row_t rows[$];
    obs_t obs, exp;
    rows.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 1, 2'b01, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 1, 2'b01, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 2'b01, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 1, 2'b01, 0, 1));
    rows.push_back(mk(0, 0, 0, 1, 0, 2'b01, 0, 2));
    rows.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 2));
    foreach (rows[i]) begin
      drive(rows[i]);
      obs = sample();
      exp = sb_q.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL pending[%0d] got %s expected %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_simultaneous();
    row_t rows[$];
    obs_t obs, exp;
    rows.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0));
    for (int k = 1; k <= 7; k++) rows.push_back(mk(0, 1, 0, 0, 0, 2'b00, 4'(k), 0));
    rows.push_back(mk(0, 1, 1, 0, 1, 2'b11, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 2'b11, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 1));
    foreach (rows[i]) begin
      drive(rows[i]);
      obs = sample();
      exp = sb_q.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL simultaneous[%0d] got %s expected %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    obs_t obs, exp;
    rows.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 1, 2'b01, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 2'b01, 0, 1));
    rows.push_back(mk(0, 0, 1, 0, 1, 2'b01, 0, 1));
    rows.push_back(mk(0, 0, 0, 1, 0, 2'b01, 0, 2));
    rows.push_back(mk(0, 0, 1, 1, 0, 2'b01, 0, 2));
    rows.push_back(mk(0, 0, 0, 0, 1, 2'b01, 0, 2));
    rows.push_back(mk(0, 0, 0, 1, 0, 2'b01, 0, 3));
    rows.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 3));
    foreach (rows[i]) begin
      drive(rows[i]);
      obs = sample();
      exp = sb_q.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL back_to_back[%0d] got %s expected %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    obs_t obs, exp;
    rows.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 2'b00, 1, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2, 0));
    rows.push_back(mk(0, 0, 1, 0, 1, 2'b01, 2, 0));
    rows.push_back(mk(0, 0, 1, 0, 1, 2'b01, 2, 0));
    rows.push_back(mk(1, 1, 1, 1, 0, 2'b00, 0, 0));
    for (int k = 0; k < 4; k++) rows.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      obs = sample();
      exp = sb_q.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reset_mid[%0d] got %s expected %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_esc_saturate();
    obs_t obs, exp;
    int   n;
    drive(mk(1, 0, 0, 0, 0, 2'b00, 0, 0));
    void'(sb_q.pop_front());
    for (int h = 0; h < 258; h++) begin
      n = (h + 1 > 255) ? 255 : h + 1;
      for (int p = 0; p < 3; p++) begin
        case (p)
          0:       drive(mk(0, 0, 1, 0, 1, 2'b01, 0, 8'((h > 255) ? 255 : h)));
          1:       drive(mk(0, 0, 0, 1, 0, 2'b01, 0, 8'(n)));
          default: drive(mk(0, 0, 0, 0, 0, 2'b00, 0, 8'(n)));
        endcase
        obs = sample();
        exp = sb_q.pop_front();
        if (h >= 253 || p == 0) begin
          total++;
          if (obs !== exp) begin
            bad++;
            $display("FAIL esc_saturate[%0d.%0d] got %s expected %s", h, p, fmt(obs), fmt(exp));
          end
        end
      end
    end
  endtask

  // Expected minor count after the edge that closes cycle t (t=0 is the
  // first cycle after reset); wraps fall on t = 1023, 2047, 3071, ...
  function automatic logic [3:0] exp_leak(input int t);
    if (t < 1024)  return 4'd0;
    if (t == 1024) return 4'd1;
    if (t == 1025) return 4'd2;
    if (t < 2047)  return 4'd3;
    if (t < 3071)  return 4'd2;
    if (t < 4095)  return 4'd1;
    if (t == 4095) return 4'd0;
    if (t < 6143)  return 4'd1;
    return 4'd0;
  endfunction

  task automatic test_leak();
    obs_t obs, exp;
    logic mi;
    drive(mk(1, 0, 0, 0, 0, 2'b00, 0, 0));
    obs = sample();
    exp = sb_q.pop_front();
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL leak_reset got %s expected %s", fmt(obs), fmt(exp));
    end
    for (int t = 0; t < 6200; t++) begin
      mi = (t >= 1024 && t <= 1026) || (t == 4096) || (t == 5119);
      drive(mk(0, mi, 0, 0, 0, 2'b00, exp_leak(t), 0));
      obs = sample();
      exp = sb_q.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL leak[t=%0d] got %s expected %s", t, fmt(obs), fmt(exp));
      end
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.alert_minor_i = 1'b0;
    bus.alert_major_i = 1'b0;
    bus.esc_ack_i     = 1'b0;
    @(negedge clk);
    test_reset();
    test_major();
    test_threshold();
    test_pending();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_esc_saturate();
    test_leak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
